// File: rtl/cpu_top.sv
// Single-cycle RV32I core: fetch, execute and commit in one clk cycle.
// Separate instruction and data buses; data bus is a shared tri-state DDT.
module cpu_top #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ACKI_n,
    input  logic [XLEN-1:0] IDT,
    input  logic            ACKD_n,
    input  logic [2:0]      OINT_n,
    output logic [XLEN-1:0] IAD,
    output logic [XLEN-1:0] DAD,
    output logic            MREQ,
    output logic            WRITE,
    output logic [1:0]      SIZE,
    output logic            IACK_n,
    inout  wire  [XLEN-1:0] DDT
);

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcode_e;

    logic [XLEN-1:0] regs [32];
    logic [XLEN-1:0] pc;

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] pc_plus4, next_pc, wb_val, alu_b, alu_out, load_val;
    logic            wb_en, is_load, is_store, mem_valid, alu_ok, alu_alt, taken, branch_ok, stall;
    logic [1:0]      mem_size;
    logic            unused;

    assign opcode  = IDT[6:0];
    assign rd      = IDT[11:7];
    assign funct3  = IDT[14:12];
    assign rs1     = IDT[19:15];
    assign rs2     = IDT[24:20];
    assign funct7  = IDT[31:25];

    assign imm_i = {{(XLEN-12){IDT[31]}}, IDT[31:20]};
    assign imm_s = {{(XLEN-12){IDT[31]}}, IDT[31:25], IDT[11:7]};
    assign imm_b = {{(XLEN-13){IDT[31]}}, IDT[31], IDT[7], IDT[30:25], IDT[11:8], 1'b0};
    assign imm_u = {IDT[31:12], 12'h000};
    assign imm_j = {{(XLEN-21){IDT[31]}}, IDT[31], IDT[19:12], IDT[20], IDT[30:21], 1'b0};

    assign rs1_val  = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? '0 : regs[rs2];
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        alu_ok = 1'b1;
        if (opcode == OP_REG)
            alu_ok = (funct7 == 7'h00) || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
        else if (funct3 == 3'b001)
            alu_ok = (funct7 == 7'h00);
        else if (funct3 == 3'b101)
            alu_ok = (funct7 == 7'h00) || (funct7 == 7'h20);
    end

    assign alu_alt = funct7[5] && (opcode == OP_REG || funct3 == 3'b101);
    assign alu_b   = (opcode == OP_REG) ? rs2_val : imm_i;

    always_comb begin
        alu_out = '0;
        case (funct3)
            3'b000: alu_out = alu_alt ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001: alu_out = rs1_val << alu_b[4:0];
            3'b010: alu_out = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(alu_b)};
            3'b011: alu_out = {{(XLEN-1){1'b0}}, rs1_val < alu_b};
            3'b100: alu_out = rs1_val ^ alu_b;
            3'b101: alu_out = alu_alt ? $unsigned($signed(rs1_val) >>> alu_b[4:0]) : rs1_val >> alu_b[4:0];
            3'b110: alu_out = rs1_val | alu_b;
            default: alu_out = rs1_val & alu_b;
        endcase
    end

    always_comb begin
        taken     = 1'b0;
        branch_ok = 1'b1;
        case (funct3)
            3'b000: taken = (rs1_val == rs2_val);
            3'b001: taken = (rs1_val != rs2_val);
            3'b100: taken = ($signed(rs1_val) < $signed(rs2_val));
            3'b101: taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110: taken = (rs1_val < rs2_val);
            3'b111: taken = (rs1_val >= rs2_val);
            default: branch_ok = 1'b0;
        endcase
    end

    // Memory returns data in the low lanes; only extension happens here.
    always_comb begin
        case (funct3)
            3'b000: load_val = {{(XLEN-8){DDT[7]}}, DDT[7:0]};
            3'b001: load_val = {{(XLEN-16){DDT[15]}}, DDT[15:0]};
            3'b100: load_val = {{(XLEN-8){1'b0}}, DDT[7:0]};
            3'b101: load_val = {{(XLEN-16){1'b0}}, DDT[15:0]};
            default: load_val = DDT;
        endcase
    end

    always_comb begin
        wb_en    = 1'b0;
        wb_val   = pc_plus4;
        next_pc  = pc_plus4;
        is_load  = 1'b0;
        is_store = 1'b0;
        mem_size = 2'b00;
        case (opcode)
            OP_LUI: begin
                wb_en  = 1'b1;
                wb_val = imm_u;
            end
            OP_AUIPC: begin
                wb_en  = 1'b1;
                wb_val = pc + imm_u;
            end
            OP_JAL: begin
                wb_en   = 1'b1;
                next_pc = pc + imm_j;
            end
            OP_JALR: if (funct3 == 3'b000) begin
                wb_en   = 1'b1;
                next_pc = (rs1_val + imm_i) & ~32'd1;
            end
            OP_BRANCH: if (branch_ok && taken) next_pc = pc + imm_b;
            OP_LOAD: if (funct3 != 3'b011 && funct3[2:1] != 2'b11) begin
                is_load  = 1'b1;
                wb_en    = 1'b1;
                wb_val   = load_val;
                mem_size = (funct3[1:0] == 2'b00) ? 2'b10 : (funct3[1:0] == 2'b01) ? 2'b01 : 2'b00;
            end
            OP_STORE: if (funct3[2] == 1'b0 && funct3[1:0] != 2'b11) begin
                is_store = 1'b1;
                mem_size = (funct3[1:0] == 2'b00) ? 2'b10 : (funct3[1:0] == 2'b01) ? 2'b01 : 2'b00;
            end
            OP_IMM, OP_REG: if (alu_ok) begin
                wb_en  = 1'b1;
                wb_val = alu_out;
            end
            default: ;
        endcase
    end

    // Data requests are suppressed while in reset or while IDT is not yet valid.
    assign mem_valid = (is_load || is_store) && !rst && !ACKI_n;
    assign stall     = ACKI_n || (mem_valid && ACKD_n);

    assign IAD    = pc;
    assign DAD    = rs1_val + (is_store ? imm_s : imm_i);
    assign MREQ   = mem_valid;
    assign WRITE  = mem_valid && is_store;
    assign SIZE   = mem_valid ? mem_size : 2'b00;
    assign IACK_n = 1'b1;
    assign DDT    = (mem_valid && is_store) ? rs2_val : {XLEN{1'bz}};
    assign unused = ^OINT_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            for (int unsigned i = 0; i < 32; i++) regs[i[4:0]] <= '0;
        end else if (!stall) begin
            pc <= next_pc;
            if (wb_en && rd != 5'd0) regs[rd] <= wb_val;
        end
    end

endmodule

// File: tb/tb_cpu_top.sv
// Bench for cpu_top: directed program followed by random RV32I instructions,
// checked cycle by cycle against an instruction-level model with random stalls.
module tb_cpu_top;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        acki_n = 1'b0;
    logic        ackd_n = 1'b0;
    logic [2:0]  oint_n = 3'b111;
    logic [31:0] iad, dad, idt;
    logic        mreq, write, iack_n;
    logic [1:0]  size;
    wire  [31:0] ddt;
    logic        ddt_en = 1'b0;
    logic [31:0] ddt_val = '0;

    logic [31:0] imem [256];
    logic [31:0] dmem [logic [31:0]];
    logic [31:0] xr [32];
    logic [31:0] mpc;
    int          wp = 0;
    int          tests = 0;
    int          fails = 0;

    assign ddt = ddt_en ? ddt_val : {32{1'bz}};
    assign idt = (iad[31:10] == 22'd0) ? imem[iad[9:2]] : 32'h0000_0013;

    always #5 clk = ~clk;

    cpu_top #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .ACKI_n(acki_n), .IDT(idt), .ACKD_n(ackd_n), .OINT_n(oint_n),
        .IAD(iad), .DAD(dad), .MREQ(mreq), .WRITE(write), .SIZE(size), .IACK_n(iack_n), .DDT(ddt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (pc %h)", tag, got, exp, mpc);
        end
    endtask

    localparam logic [6:0] OPI = 7'b0010011, LD = 7'b0000011, LUI = 7'b0110111,
                           AUI = 7'b0010111, JALR = 7'b1100111;

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
        logic [11:0] i = 12'(imm);
        return {i, 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction
    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
        logic [11:0] i = 12'(imm);
        return {i[11:5], 5'(rs2), 5'(rs1), 3'(f3), i[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        logic [12:0] i = 13'(imm);
        return {i[12], i[10:5], 5'(rs2), 5'(rs1), 3'(f3), i[4:1], i[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(int imm20, int rd, logic [6:0] op);
        return {20'(imm20), 5'(rd), op};
    endfunction
    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [20:0] i = 21'(imm);
        return {i[20], i[10:1], i[11], i[19:12], 5'(rd), 7'b1101111};
    endfunction

    task automatic put(input logic [31:0] w);
        imem[wp] = w;
        wp++;
    endtask

    function automatic int pick_reg();
        int r;
        do r = int'($urandom_range(1, 31)); while (r == 5 || r == 14);
        return r;
    endfunction

    function automatic logic [31:0] dmem_read(logic [31:0] a);
        if (dmem.exists(a)) return dmem[a];
        return {~a[15:0], a[15:0] ^ 16'h8A51};
    endfunction

    typedef struct {
        logic        mreq, wr, wb;
        logic [1:0]  size;
        logic [31:0] addr, sdata, ldata, wbval, npc;
        int          rd;
    } step_t;

    function automatic logic [31:0] alu(int f3, bit alt, logic [31:0] a, logic [31:0] b);
        int unsigned sh = b[4:0];
        case (f3)
            0: return alt ? a - b : a + b;
            1: return a << sh;
            2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3: return (a < b) ? 32'd1 : 32'd0;
            4: return a ^ b;
            5: return alt ? $unsigned($signed(a) >>> sh) : a >> sh;
            6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Architectural effect of one instruction, from the ISA definition.
    function automatic step_t model_step(logic [31:0] ins, logic [31:0] pc);
        step_t s;
        int f3 = int'(ins[14:12]);
        logic [31:0] a = xr[ins[19:15]];
        logic [31:0] b = xr[ins[24:20]];
        logic [31:0] ii = {{20{ins[31]}}, ins[31:20]};
        logic [31:0] is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        logic [31:0] ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        logic [31:0] ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        logic [31:0] d;
        bit t;
        s = '{mreq: 1'b0, wr: 1'b0, wb: 1'b0, size: 2'b00, addr: '0, sdata: '0, ldata: '0,
              wbval: pc + 32'd4, npc: pc + 32'd4, rd: int'(ins[11:7])};
        case (ins[6:0])
            7'b0110111: begin s.wb = 1'b1; s.wbval = {ins[31:12], 12'h000}; end
            7'b0010111: begin s.wb = 1'b1; s.wbval = pc + {ins[31:12], 12'h000}; end
            7'b1101111: begin s.wb = 1'b1; s.npc = pc + ij; end
            7'b1100111: begin s.wb = 1'b1; s.npc = (a + ii) & 32'hFFFF_FFFE; end
            7'b1100011: begin
                case (f3)
                    0: t = (a == b);
                    1: t = (a != b);
                    4: t = ($signed(a) < $signed(b));
                    5: t = ($signed(a) >= $signed(b));
                    6: t = (a < b);
                    default: t = (a >= b);
                endcase
                if (t) s.npc = pc + ib;
            end
            7'b0000011: begin
                s.mreq = 1'b1; s.wb = 1'b1; s.addr = a + ii;
                d = dmem_read(s.addr);
                s.ldata = d;
                case (f3)
                    0: begin s.size = 2'b10; s.wbval = {{24{d[7]}}, d[7:0]}; end
                    1: begin s.size = 2'b01; s.wbval = {{16{d[15]}}, d[15:0]}; end
                    4: begin s.size = 2'b10; s.wbval = {24'd0, d[7:0]}; end
                    5: begin s.size = 2'b01; s.wbval = {16'd0, d[15:0]}; end
                    default: begin s.size = 2'b00; s.wbval = d; end
                endcase
            end
            7'b0100011: begin
                s.mreq = 1'b1; s.wr = 1'b1; s.addr = a + is; s.sdata = b;
                s.size = (f3 == 0) ? 2'b10 : (f3 == 1) ? 2'b01 : 2'b00;
            end
            7'b0010011: begin s.wb = 1'b1; s.wbval = alu(f3, (f3 == 5) && ins[30], a, ii); end
            7'b0110011: begin s.wb = 1'b1; s.wbval = alu(f3, ins[30], a, b); end
            default: ;
        endcase
        return s;
    endfunction

    // Store values the directed program must produce, worked out by hand.
    function automatic bit spec_store(input logic [31:0] pc, output logic [31:0] v, output logic [31:0] m);
        m = 32'hFFFF_FFFF;
        case (pc)
            32'h18: v = 32'h0000_0002;
            32'h30: v = 32'h0000_0024;
            32'h34: v = 32'hFFFF_FFF8;
            32'h38: v = 32'h0000_0002;
            32'h3C: v = 32'h0000_0000;
            32'h4C: v = 32'hFFFF_FF80;
            32'h50: v = 32'h0000_0080;
            32'h54: v = 32'hFFFF_8001;
            32'h74: v = 32'h0000_0070;
            32'h80: begin v = 32'h0000_0041; m = 32'h0000_00FF; end
            32'h84: v = 32'h0000_0000;
            default: begin v = '0; return 1'b0; end
        endcase
        return 1'b1;
    endfunction

    task automatic build_program();
        int k, f3, r;
        for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
        put(enc_i(5, 0, 0, 1, OPI));          put(enc_i(-3, 0, 0, 2, OPI));
        put(enc_r(0, 2, 1, 0, 3));            put(enc_r(32, 1, 2, 0, 4));
        put(enc_i(1, 0, 0, 0, OPI));          put(enc_u(20'h08000, 5, LUI));
        put(enc_s(0, 3, 5, 2));               put(enc_i(0, 5, 2, 6, LD));
        put(enc_j(16, 1));
        for (int i = 0; i < 3; i++) put(enc_i(-1, 0, 0, 31, OPI));
        put(enc_s(4, 1, 5, 2));               put(enc_s(8, 4, 5, 2));
        put(enc_s(12, 6, 5, 2));              put(enc_s(16, 0, 5, 2));
        put(enc_i(32, 5, 0, 8, LD));          put(enc_i(32, 5, 4, 9, LD));
        put(enc_i(36, 5, 1, 10, LD));
        put(enc_s(20, 8, 5, 2));              put(enc_s(24, 9, 5, 2));
        put(enc_s(28, 10, 5, 2));
        put(enc_b(8, 0, 0, 0));               put(enc_i(-1, 0, 0, 31, OPI));
        put(enc_b(8, 0, 1, 0));               put(enc_i(59, 0, 0, 11, OPI));
        put(enc_i(116, 0, 0, 12, OPI));       put(enc_i(1, 12, 0, 13, JALR));
        put(enc_i(-1, 0, 0, 31, OPI));        put(enc_s(32, 13, 5, 2));
        put(enc_i(65, 0, 0, 7, OPI));         put(enc_u(20'hF0000, 14, LUI));
        put(enc_s(0, 7, 14, 0));              put(enc_s(36, 31, 5, 2));
        dmem[32'h0800_0020] = 32'h0000_0080;
        dmem[32'h0800_0024] = 32'h0000_8001;
        while (wp < 180) begin
            k = int'($urandom_range(0, 9));
            r = pick_reg();
            f3 = int'($urandom_range(0, 7));
            case (k)
                0, 1, 2: begin
                    if (f3 == 1) put(enc_i(int'($urandom_range(0, 31)), pick_reg(), 1, r, OPI));
                    else if (f3 == 5) put(enc_i(int'($urandom_range(0, 1)) * 1024 + int'($urandom_range(0, 31)),
                                                pick_reg(), 5, r, OPI));
                    else put(enc_i(int'($urandom_range(0, 4095)), pick_reg(), f3, r, OPI));
                end
                3, 4: put(enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 32 : 0,
                                int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), f3, r));
                5: put(enc_u(int'($urandom_range(0, 20'hFFFFF)), r, ($urandom_range(0, 1) == 1) ? LUI : AUI));
                6: begin
                    case ($urandom_range(0, 4))
                        0: f3 = 0; 1: f3 = 1; 2: f3 = 2; 3: f3 = 4; default: f3 = 5;
                    endcase
                    put(enc_i(int'($urandom_range(0, 255)), 5, f3, r, LD));
                end
                7: put(enc_s(int'($urandom_range(0, 255)), int'($urandom_range(0, 31)), 5,
                             int'($urandom_range(0, 2))));
                8: begin
                    if (f3 == 2 || f3 == 3) f3 = f3 + 4;
                    put(enc_b(8, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), f3));
                end
                default: put(enc_j(8, r));
            endcase
        end
        for (int i = 1; i < 32; i++) put(enc_s(256 + 4 * i, i, 5, 2));
        put(enc_u(20'hFF000, 15, LUI));
        put(enc_s(0, 0, 15, 2));
    endtask

    initial begin
        step_t       st;
        logic [31:0] ins, sv, sm;
        bit          commit, done;
        int          sb_hold;

        done = 1'b0;
        sb_hold = 0;
        mpc = '0;
        for (int i = 0; i < 32; i++) xr[i] = '0;
        build_program();

        @(negedge clk);
        check_eq("rst_iad", iad, 32'h0);
        check_eq("rst_mreq", 32'(mreq), 32'd0);
        check_eq("rst_write", 32'(write), 32'd0);
        check_eq("rst_size", 32'(size), 32'd0);
        check_eq("rst_iack", 32'(iack_n), 32'd1);
        check_eq("rst_ddt_hiz", 32'(ddt === {32{1'bz}}), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            acki_n = (cyc >= 3) && ($urandom_range(0, 7) == 0);
            ackd_n = (cyc >= 3) && ($urandom_range(0, 3) == 0);
            ins = (mpc[31:10] == 22'd0) ? imem[mpc[9:2]] : 32'h0000_0013;
            st = model_step(ins, mpc);
            if (st.wr && st.addr == 32'hF000_0000 && sb_hold < 2) begin
                acki_n = 1'b0;
                ackd_n = 1'b1;
                sb_hold++;
            end
            ddt_en  = st.mreq && !st.wr && !acki_n;
            ddt_val = st.ldata;

            @(negedge clk);
            check_eq("iad", iad, mpc);
            check_eq("iack_n", 32'(iack_n), 32'd1);
            if (!acki_n) begin
                check_eq("mreq", 32'(mreq), 32'(st.mreq));
                if (st.mreq) begin
                    check_eq("write", 32'(write), 32'(st.wr));
                    check_eq("size", 32'(size), 32'(st.size));
                    check_eq("dad", dad, st.addr);
                    if (st.wr) begin
                        check_eq("store_data", ddt, st.sdata);
                        if (spec_store(mpc, sv, sm)) check_eq("directed_store", ddt & sm, sv);
                        if (mpc == 32'h80) check_eq("console_sb_size", 32'(size), 32'd2);
                    end
                end else begin
                    check_eq("ddt_hiz", 32'(ddt === {32{1'bz}}), 32'd1);
                end
            end
            commit = !acki_n && !(st.mreq && ackd_n);

            @(posedge clk);
            if (commit) begin
                if (st.wb && st.rd != 0) xr[st.rd] = st.wbval;
                if (st.wr) begin
                    dmem[st.addr] = st.sdata;
                    if (st.addr == 32'hFF00_0000) done = 1'b1;
                end
                mpc = st.npc;
            end
            #1;
        end
        ddt_en = 1'b0;
        check_eq("exit_reached", 32'(done), 32'd1);
        check_eq("console_stall_seen", 32'(sb_hold), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
